// File: rtl/autocell_ctrl.sv
// autocell_ctrl: run controller for the W-cell autocell automaton datapath.
// Loads a seed pattern and advances the datapath for up to `steps`
// generations. It stops early on a fixed point and reports the generation
// count and population through a start/done handshake.
// Optional feature macro: AUTOCELL_CTRL_FLUX_EN. When it is defined, the
// traffic flux of every pre-step state is accumulated into o_flux_sum,
// saturating at the top of the range. When it is undefined, o_flux_sum is
// tied to 0 and no flux logic is built.
module autocell_ctrl #(
  parameter int W  = 20,
  parameter int SW = 8,
  parameter int PW = 5,
  parameter int FW = 16
) (
  input  logic          i_clk,
  input  logic          i_res,
  input  logic          i_start,
  input  logic [W-1:0]  i_seed,
  input  logic [SW-1:0] i_steps,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_stable,
  output logic [SW-1:0] o_gen_count,
  output logic [PW-1:0] o_pop,
  output logic [FW-1:0] o_flux_sum,
  output logic          o_ca_load,
  output logic [W-1:0]  o_ca_seed,
  output logic          o_ca_step,
  input  logic [W-1:0]  i_ca_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    r_state;
  logic [1:0]    w_nxt;
  logic [W-1:0]  r_seed;
  logic [SW-1:0] r_steps;
  logic [SW-1:0] r_gen;
  logic [W-1:0]  r_prev;
  logic          r_stable;
  logic          r_done;
  logic [PW-1:0] r_pop;

  logic          w_run;
  logic          w_fp;
  logic          w_step;
  logic          w_last;
  logic [SW-1:0] w_gen_inc;

  // Number of live cells in a ring state.
  function automatic logic [PW-1:0] f_pop(input logic [W-1:0] s);
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < W; i++) c = c + PW'(s[i]);
    return c;
  endfunction

  assign w_run     = (r_state == S_RUN);
  // prev only holds a real earlier generation once one step has been applied
  assign w_fp      = (r_gen != '0) && (i_ca_state == r_prev);
  assign w_step    = w_run && !w_fp && (r_gen < r_steps);
  // r_gen < r_steps whenever w_step is set, so the increment cannot wrap
  assign w_gen_inc = r_gen + 1'b1;
  // The final step and the move to DONE share one edge. This keeps the
  // start-to-done latency at steps+1.
  assign w_last    = w_step && (w_gen_inc == r_steps);

  // Next-state decode; RUN leaves as soon as no further step will be issued
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: if (i_start) w_nxt = S_LOAD;
      S_LOAD: w_nxt = (r_steps == '0) ? S_DONE : S_RUN;
      S_RUN:  if (!w_step || w_last) w_nxt = S_DONE;
      S_DONE: w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // State, run parameters, generation counter, fixed-point tracking and results
  always_ff @(posedge i_clk or negedge i_res) begin
    if (!i_res) begin
      r_state  <= S_IDLE;
      r_seed   <= '0;
      r_steps  <= '0;
      r_gen    <= '0;
      r_prev   <= '0;
      r_stable <= 1'b0;
      r_done   <= 1'b0;
      r_pop    <= '0;
    end else begin
      r_state <= w_nxt;
      r_done  <= (w_nxt == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_seed   <= i_seed;
            r_steps  <= i_steps;
            r_gen    <= '0;
            r_stable <= 1'b0;
          end
        end
        S_RUN: begin
          r_prev <= i_ca_state;
          if (w_step) r_gen <= w_gen_inc;
          if (w_fp) r_stable <= 1'b1;
        end
        // The datapath holds the final state during DONE. The population is
        // captured on the edge that leaves DONE.
        S_DONE: r_pop <= f_pop(i_ca_state);
        default: ;
      endcase
    end
  end

`ifdef AUTOCELL_CTRL_FLUX_EN
  logic [FW-1:0] r_flux;
  logic [PW-1:0] w_flux;
  logic [FW:0]   w_flux_add;

  // Flux of the current (pre-step) state: occupied cells whose successor
  // cell is empty. Index W-1 wraps around to 0.
  always_comb begin
    w_flux = '0;
    for (int i = 0; i < W; i++)
      w_flux = w_flux + PW'(i_ca_state[i] & ~i_ca_state[(i + 1) % W]);
  end

  assign w_flux_add = {1'b0, r_flux} + (FW+1)'(w_flux);

  // Saturating flux accumulator. It is cleared on an accepted start and
  // advances on each step edge.
  always_ff @(posedge i_clk or negedge i_res) begin
    if (!i_res) r_flux <= '0;
    else if (r_state == S_IDLE && i_start) r_flux <= '0;
    else if (w_step) r_flux <= w_flux_add[FW] ? '1 : w_flux_add[FW-1:0];
  end

  assign o_flux_sum = r_flux;
`else
  assign o_flux_sum = '0;
`endif

  assign o_busy      = (r_state == S_LOAD) || w_run;
  assign o_ca_load   = (r_state == S_LOAD);
  assign o_ca_step   = w_step;
  assign o_done      = r_done;
  assign o_stable    = r_stable;
  assign o_gen_count = r_gen;
  assign o_pop       = r_pop;
  assign o_ca_seed   = r_seed;

endmodule

// File: tb/tb_autocell_ctrl.sv
// tb_autocell_ctrl: directed, table-driven bench for autocell_ctrl.
// A rule-184 ring stands in for the autocell datapath. Cars move toward
// higher indices and wrap from W-1 to 0.
`timescale 1ns/100ps
module tb_autocell_ctrl;
  localparam int W  = 20;
  localparam int SW = 8;
  localparam int PW = 5;
  localparam int FW = 16;

  logic          clk = 1'b0;
  logic          res = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  seed = '0;
  logic [SW-1:0] steps = '0;
  logic          busy, done, stable, ca_load, ca_step;
  logic [SW-1:0] gen_count;
  logic [PW-1:0] pop;
  logic [FW-1:0] flux_sum;
  logic [W-1:0]  ca_seed;
  logic [W-1:0]  ca_state = '0;

  int n_chk  = 0;
  int n_fail = 0;
  int n_load = 0;
  int n_step = 0;

  typedef struct {
    logic [W-1:0]  seed;
    logic [SW-1:0] steps;
    int            gen;
    int            pop;
    logic          stbl;
    int            flux;
    int            lat;
  } vec_t;

  vec_t vt[9];

  always #5 clk = ~clk;

  autocell_ctrl #(.W(W), .SW(SW), .PW(PW), .FW(FW)) dut (
    .i_clk(clk), .i_res(res), .i_start(start), .i_seed(seed), .i_steps(steps),
    .o_busy(busy), .o_done(done), .o_stable(stable), .o_gen_count(gen_count),
    .o_pop(pop), .o_flux_sum(flux_sum), .o_ca_load(ca_load), .o_ca_seed(ca_seed),
    .o_ca_step(ca_step), .i_ca_state(ca_state)
  );

  function automatic logic [W-1:0] rule184(input logic [W-1:0] s);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++)
      r[i] = (s[(i + W - 1) % W] & ~s[i]) | (s[i] & s[(i + 1) % W]);
    return r;
  endfunction

  // Datapath stand-in: reset leaves it untouched
  always @(posedge clk) begin
    if (ca_load) ca_state <= ca_seed;
    else if (ca_step) ca_state <= rule184(ca_state);
  end

  // Strobe counters, read as differences around each run
  always @(posedge clk) begin
    if (ca_load) n_load <= n_load + 1;
    if (ca_step) n_step <= n_step + 1;
  end

  function automatic int exp_flux(input int f);
`ifdef AUTOCELL_CTRL_FLUX_EN
    return f;
`else
    return (f == -1) ? 1 : 0;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat, l0, s0;
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    seed = v.seed; steps = v.steps; start = 1'b1;
    l0 = n_load; s0 = n_step;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    chk({tag, " load strobe"}, int'(ca_load), 1);
    chk({tag, " busy in load"}, int'(busy), 1);
    while (!done && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, lat, v.lat);
    chk({tag, " gen_count"}, int'(gen_count), v.gen);
    chk({tag, " stable"}, int'(stable), int'(v.stbl));
    chk({tag, " flux_sum"}, int'(flux_sum), exp_flux(v.flux));
    chk({tag, " busy in done"}, int'(busy), 0);
    @(negedge clk);
    chk({tag, " pop"}, int'(pop), v.pop);
    chk({tag, " done one cycle"}, int'(done), 0);
    chk({tag, " stable held"}, int'(stable), int'(v.stbl));
    chk({tag, " load count"}, n_load - l0, 1);
    chk({tag, " step count"}, n_step - s0, v.gen);
  endtask

  initial begin
    int cnt;
    //        seed                       steps   gen  pop stbl  flux  lat
    vt[0] = '{20'hAAAAA,                 8'd20,  20,  10, 1'b0,  200,  21};
    vt[1] = '{20'hFFFFF,                 8'd20,   1,  20, 1'b1,    0,   3};
    vt[2] = '{20'h00000,                 8'd20,   1,   0, 1'b1,    0,   3};
    vt[3] = '{20'hABCDE,                 8'd0,    0,  13, 1'b0,    0,   1};
    vt[4] = '{20'b00000010100100110001,  8'd3,    3,   6, 1'b0,   17,   4};
    vt[5] = '{20'h00001,                 8'd5,    5,   1, 1'b0,    5,   6};
    vt[6] = '{20'h80000,                 8'd2,    2,   1, 1'b0,    2,   3};
    vt[7] = '{20'hAAAAA,                 8'd1,    1,  10, 1'b0,   10,   2};
    vt[8] = '{20'hAAAAA,                 8'd255, 255, 10, 1'b0, 2550, 256};

    // Reset state
    #2;
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset ca_load", int'(ca_load), 0);
    chk("reset ca_step", int'(ca_step), 0);
    chk("reset gen_count", int'(gen_count), 0);
    chk("reset pop", int'(pop), 0);
    chk("reset ca_seed", int'(ca_seed), 0);
    @(negedge clk);
    res = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vt[i], i);

    // Asynchronous reset in the middle of a run
    @(negedge clk);
    seed = 20'hAAAAA; steps = 8'd20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (gen_count != 8'd5 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk("midrun reached gen 5", int'(gen_count), 5);
    #2 res = 1'b0;
    #0.5;
    chk("midrun rst busy", int'(busy), 0);
    chk("midrun rst ca_step", int'(ca_step), 0);
    chk("midrun rst gen_count", int'(gen_count), 0);
    chk("midrun rst pop", int'(pop), 0);
    chk("midrun rst flux_sum", int'(flux_sum), 0);
    chk("midrun rst ca_seed", int'(ca_seed), 0);
    chk("midrun rst stable", int'(stable), 0);
    #0.5 res = 1'b1;
    @(negedge clk);
    chk("after rst idle", int'(busy), 0);
    run_vec(vt[0], 100);

    // start held high: one IDLE cycle between DONE and the next LOAD
    @(negedge clk);
    seed = 20'b00000010100100110001; steps = 8'd3; start = 1'b1;
    for (int r = 0; r < 3; r++) begin
      cnt = 0;
      while (!done && cnt < 20) begin
        @(negedge clk);
        cnt++;
      end
      chk($sformatf("b2b%0d done seen", r), int'(done), 1);
      chk($sformatf("b2b%0d gen_count", r), int'(gen_count), 3);
      @(negedge clk);
      chk($sformatf("b2b%0d idle gap", r), int'(busy), 0);
      chk($sformatf("b2b%0d pop", r), int'(pop), 6);
      @(negedge clk);
      chk($sformatf("b2b%0d reload", r), int'(ca_load), 1);
      if (r == 2) start = 1'b0;
    end
    cnt = 0;
    while (!done && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("b2b last done", int'(done), 1);
    repeat (3) @(negedge clk);
    chk("b2b no queued run", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/autocell_ctrl.md
# autocell_ctrl

Run controller for the 20-cell `autocell` automaton datapath. It loads a seed pattern, advances the automaton for a requested number of generations, and stops early when the pattern reaches a fixed point. At completion it reports the generation count and population, and optionally the accumulated traffic flux. It sits between the host/testbench and one `autocell` instance, replacing free-running clock-and-reset sequencing with a start/done handshake.

## Interface
- `W`, 20, number of cells; ring width of `seed`, `ca_seed`, `ca_state`
- `SW`, 8, width of `steps` and `gen_count`
- `PW`, 5, width of `pop`; must hold W (⌈log2(W+1)⌉)
- `FW`, 16, width of `flux_sum`

- `clk`  in  1  system clock, rising edge
- `res`  in  1  asynchronous active-low reset
- `start`  in  1  run request, sampled in IDLE only
- `seed`  in  W  initial pattern, captured with `start`
- `steps`  in  SW  generation limit, captured with `start`
- `busy`  out  1  high in LOAD and RUN
- `done`  out  1  one-cycle completion pulse
- `stable`  out  1  last run ended on a fixed point; held until next `start`
- `gen_count`  out  SW  generations actually applied in the current/last run
- `pop`  out  PW  number of 1 cells in the final state, registered at DONE
- `flux_sum`  out  FW  accumulated flux (only with the macro; else tied 0)
- `ca_load`  out  1  datapath load strobe; datapath takes `ca_seed` on the edge where high
- `ca_seed`  out  W  latched seed
- `ca_step`  out  1  datapath advance enable; one generation per edge where high
- `ca_state`  in  W  current datapath state

## Operation
- FSM states: IDLE, LOAD, RUN, DONE. Reset state is IDLE.
- IDLE:
  - `start`=1 latches `seed` and `steps`, clears `gen_count`, `stable`, and `flux_sum`, then goes to LOAD.
- LOAD:
  - `ca_load`=1 for exactly one cycle.
  - Next state is RUN, or DONE if the latched steps = 0.
- RUN:
  - `prev` register samples `ca_state` every cycle.
  - Fixed point `fp` is the combinational term `gen_count`≥1 && `ca_state`==`prev`.
  - `ca_step` = RUN && !`fp` && `gen_count`<steps.
  - On each edge with `ca_step`=1, `gen_count` increments.
  - When `fp` is true, go to DONE, set `stable`=1, and issue no further step.
  - When `gen_count`==steps, go to DONE.
- DONE:
  - `done`=1 and `pop` is registered as popcount(`ca_state`).
  - Next state is IDLE unconditionally.
- `start` in LOAD, RUN or DONE is ignored, with no queuing.
- Flux of a state is the count of i where `ca_state[i]`=1 and `ca_state[(i+1) mod W]`=0. Index W-1 wraps to 0.
- Reset mid-run: all outputs and registers go to 0 immediately and the FSM goes to IDLE. The datapath content is not touched, but the next run reloads it.

## Timing
- Reset values: `busy`, `done`, `stable`, `ca_load`, `ca_step` = 0; `gen_count`, `pop`, `flux_sum`, `ca_seed` = 0.
- `ca_load`, `ca_step` and `busy` are decoded from the FSM state. All other outputs are registered.
- Timeline with `start` sampled at edge E0 and no fixed point:
  - LOAD during E0→E1; the datapath loads at E1.
  - RUN during E1→E(N+1), with steps applied at E2..E(N+1).
  - DONE during E(N+1)→E(N+2), with `done` high.
- Latency from `start` to `done` is N+1 cycles. With steps=0 it is 1 cycle.
- Back-to-back: `start` may be accepted at the edge leaving DONE→IDLE+1, i.e. one idle cycle minimum.
- `gen_count` saturates at the latched steps and never wraps. `flux_sum` saturates at 2^FW−1.

## Configuration
- `AUTOCELL_CTRL_FLUX_EN` defined:
  - In RUN, on each edge with `ca_step`=1, `flux_sum` += flux(`ca_state`), computed on the pre-step state and saturating.
  - Total flux is taken over generations 0..N−1.
- Undefined: no flux logic is built and `flux_sum` is constant 0.

## Test plan
- Reset mid-run: `res` low for 1 ns during RUN at `gen_count`=5 → all outputs 0 asynchronously, FSM in IDLE. A new run then completes normally.
- Seed `10101010101010101010`, steps=20 (rule-184 datapath) → `done` 21 cycles after `start`, `gen_count`=20, `pop`=10, `stable`=0, `flux_sum`=200 (0 without the macro).
- Seed all-ones, steps=20 → `stable`=1, `gen_count`=1, `pop`=20, `flux_sum`=0. Seed all-zeros gives the same with `pop`=0.
- Steps=0, any seed → `ca_load` pulse, `done` 1 cycle after `start`, `ca_step` never high, `gen_count`=0, `pop`=popcount(seed).
- `start` held high continuously with seed `00000010100100110001`, steps=3 → runs repeat with exactly one IDLE cycle between DONE and next LOAD. `start` pulses during RUN have no effect. `pop`=6 if the rule conserves cells.
